gba_sram_frontend: RTL and testbench

Asynchronous GBA cartridge SRAM-port front end that sits directly upstream of the GBARam card bus. It synchronises the cartridge pins (/CS2, /RD, /WR, A[15:0], D[7:0]) into the FPGA clock domain and runs a small state machine. Each /WR strobe becomes exactly one single-cycle `io_card_bus_write` transaction. Reads drive the card-bus address and return `io_card_bus_miso` on the cartridge data pins with an output enable.

---
 rtl/gba_sram_frontend.sv | 137 +++++++++++++
 tb/tb_gba_sram_frontend.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gba_sram_frontend.sv
// rtl/gba_sram_frontend.sv - GBA cartridge SRAM-port front end onto the GBARam card bus
// Synchronises the asynchronous cartridge pins and turns strobes into card-bus transactions.
module gba_sram_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_gba_cs2_n,
  input  logic        io_gba_rd_n,
  input  logic        io_gba_wr_n,
  input  logic [15:0] io_gba_addr,
  input  logic [7:0]  io_gba_data_in,
  output logic [7:0]  io_gba_data_out,
  output logic        io_gba_data_oe,
  output logic [15:0] io_card_bus_addr,
  output logic [7:0]  io_card_bus_mosi,
  input  logic [7:0]  io_card_bus_miso,
  output logic        io_card_bus_write,
  output logic [15:0] io_write_count
);

  typedef enum logic [2:0] {
    ARM     = 3'd0,
    IDLE    = 3'd1,
    READ    = 3'd2,
    WRITE   = 3'd3,
    WR_HOLD = 3'd4
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0]       cs2_sync, rd_sync, wr_sync;
  logic [SYNC_STAGES-1:0][15:0] addr_sync;
  logic [SYNC_STAGES-1:0][7:0]  data_sync;

  logic        s_cs2_n, s_rd_n, s_wr_n;
  logic [15:0] s_addr;
  logic [7:0]  s_data;
  logic        rd_act, wr_act;

  logic [2:0]  arm_cnt;
  logic        arm_flushed;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      cs2_sync  <= '1;
      rd_sync   <= '1;
      wr_sync   <= '1;
      addr_sync <= '0;
      data_sync <= '0;
    end else begin
      cs2_sync  <= {cs2_sync[SYNC_STAGES-2:0], io_gba_cs2_n};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], io_gba_rd_n};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], io_gba_wr_n};
      addr_sync <= {addr_sync[SYNC_STAGES-2:0], io_gba_addr};
      data_sync <= {data_sync[SYNC_STAGES-2:0], io_gba_data_in};
    end
  end

  assign s_cs2_n = cs2_sync[SYNC_STAGES-1];
  assign s_rd_n  = rd_sync[SYNC_STAGES-1];
  assign s_wr_n  = wr_sync[SYNC_STAGES-1];
  assign s_addr  = addr_sync[SYNC_STAGES-1];
  assign s_data  = data_sync[SYNC_STAGES-1];
  assign rd_act  = !s_cs2_n && !s_rd_n;
  assign wr_act  = !s_cs2_n && !s_wr_n;

  // The strobe chains reset to "inactive", so ARM must also wait until the
  // real pin levels have propagated through before trusting rd_act/wr_act.
  assign arm_flushed = (arm_cnt == 3'(SYNC_STAGES));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ARM;
      arm_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ARM && !arm_flushed) begin
        arm_cnt <= arm_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARM:     if (arm_flushed && !rd_act && !wr_act) state_next = IDLE;
      IDLE:    if (wr_act) state_next = WRITE;
               else if (rd_act) state_next = READ;
      READ:    if (wr_act || !rd_act) state_next = IDLE;
      WRITE:   state_next = WR_HOLD;
      WR_HOLD: if (!wr_act) state_next = IDLE;
      default: state_next = ARM;
    endcase
  end

  always_comb begin
    io_card_bus_write = 1'b0;
    io_card_bus_addr  = '0;
    io_card_bus_mosi  = '0;
    case (state)
      READ:  io_card_bus_addr = s_addr;
      WRITE: begin
        io_card_bus_write = 1'b1;
        io_card_bus_addr  = wr_addr;
        io_card_bus_mosi  = wr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr         <= '0;
      wr_data         <= '0;
      io_write_count  <= '0;
      io_gba_data_out <= '0;
      io_gba_data_oe  <= 1'b0;
    end else begin
      if (state == IDLE && wr_act) begin
        wr_addr <= s_addr;
        wr_data <= s_data;
      end
      if (state == WRITE) begin
        io_write_count <= io_write_count + 16'd1;
      end
      if (state == READ) begin
        io_gba_data_out <= io_card_bus_miso;
      end
      // Output enable drops on the same edge the FSM leaves READ.
      io_gba_data_oe <= (state == READ) && rd_act && !wr_act;
    end
  end

endmodule

// File: tb/tb_gba_sram_frontend.sv
// tb/tb_gba_sram_frontend.sv - self-checking bench for gba_sram_frontend
// Pin-level stimulus against a transaction model: expected writes queue, byte memory, write count.
module tb_gba_sram_frontend;
  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_gba_cs2_n = 1'b1;
  logic        io_gba_rd_n = 1'b1;
  logic        io_gba_wr_n = 1'b1;
  logic [15:0] io_gba_addr = '0;
  logic [7:0]  io_gba_data_in = '0;
  logic [7:0]  io_gba_data_out;
  logic        io_gba_data_oe;
  logic [15:0] io_card_bus_addr;
  logic [7:0]  io_card_bus_mosi;
  logic [7:0]  io_card_bus_miso;
  logic        io_card_bus_write;
  logic [15:0] io_write_count;

  gba_sram_frontend #(.SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset),
    .io_gba_cs2_n(io_gba_cs2_n), .io_gba_rd_n(io_gba_rd_n), .io_gba_wr_n(io_gba_wr_n),
    .io_gba_addr(io_gba_addr), .io_gba_data_in(io_gba_data_in),
    .io_gba_data_out(io_gba_data_out), .io_gba_data_oe(io_gba_data_oe),
    .io_card_bus_addr(io_card_bus_addr), .io_card_bus_mosi(io_card_bus_mosi),
    .io_card_bus_miso(io_card_bus_miso), .io_card_bus_write(io_card_bus_write),
    .io_write_count(io_write_count)
  );

  always #5 clock = ~clock;

  // GBARam stand-in: combinational read, written by the card-bus strobe.
  bit [7:0] ram [65536];
  assign io_card_bus_miso = ram[io_card_bus_addr];
  always @(posedge clock) if (io_card_bus_write) ram[io_card_bus_addr] <= io_card_bus_mosi;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  bit [7:0]  model_mem [65536];
  bit        model_valid [65536];
  int        model_count = 0;
  int        checks = 0;
  int        failures = 0;
  bit        oe_allowed = 1'b0;
  bit        glitch_win = 1'b0;
  int        glitch_seen = 0;
  logic [15:0] glitch_addr = 16'h0040;
  logic [7:0]  glitch_data = 8'h7E;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  always @(negedge clock) begin
    wr_t w;
    if (!reset) begin
      if (io_card_bus_write) begin
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(io_card_bus_addr), 32'(w.a));
          check("wr_mosi", 32'(io_card_bus_mosi), 32'(w.d));
        end else if (glitch_win) begin
          glitch_seen++;
          check("glitch_addr", 32'(io_card_bus_addr), 32'(glitch_addr));
          check("glitch_mosi", 32'(io_card_bus_mosi), 32'(glitch_data));
        end else begin
          check("unexpected_write", 32'(io_card_bus_write), 32'd0);
        end
      end else begin
        check("idle_mosi", 32'(io_card_bus_mosi), 32'd0);
      end
      if (!oe_allowed) check("oe_forbidden", 32'(io_gba_data_oe), 32'd0);
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int low, input int high,
                          input bit cs_high, input bit with_rd);
    int lat;
    io_gba_addr = a;
    io_gba_data_in = d;
    io_gba_cs2_n = cs_high;
    io_gba_rd_n = !with_rd;
    io_gba_wr_n = 1'b0;
    if (!cs_high) begin
      exp_q.push_back('{a: a, d: d});
      model_mem[a] = d;
      model_valid[a] = 1'b1;
      model_count++;
    end
    lat = 0;
    for (int i = 1; i <= low; i++) begin
      tick();
      if (io_card_bus_write && lat == 0) lat = i;
    end
    if (!cs_high) check("wr_latency", 32'(lat), 32'(S + 1));
    io_gba_wr_n = 1'b1;
    io_gba_rd_n = 1'b1;
    io_gba_cs2_n = 1'b1;
    tick(high);
    check("wr_drained", 32'(exp_q.size()), 32'd0);
    check("wr_count", 32'(io_write_count), 32'(model_count[15:0]));
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input int low);
    int first;
    oe_allowed = 1'b1;
    io_gba_addr = a;
    io_gba_cs2_n = 1'b0;
    io_gba_rd_n = 1'b0;
    first = 0;
    for (int i = 1; i <= low; i++) begin
      tick();
      if (io_gba_data_oe && first == 0) first = i;
    end
    check("rd_latency", 32'(first), 32'(S + 2));
    check("rd_oe", 32'(io_gba_data_oe), 32'd1);
    check("rd_data", 32'(io_gba_data_out), 32'(exp));
    io_gba_rd_n = 1'b1;
    io_gba_cs2_n = 1'b1;
    tick(S + 2);
    check("rd_oe_drop", 32'(io_gba_data_oe), 32'd0);
    oe_allowed = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;

    // Reset held with a write strobe already low.
    reset = 1'b1;
    io_gba_cs2_n = 1'b0;
    io_gba_wr_n = 1'b0;
    io_gba_addr = 16'h1234;
    io_gba_data_in = 8'h99;
    tick(4);
    check("rst_write", 32'(io_card_bus_write), 32'd0);
    check("rst_count", 32'(io_write_count), 32'd0);
    check("rst_oe", 32'(io_gba_data_oe), 32'd0);
    check("rst_dout", 32'(io_gba_data_out), 32'd0);
    check("rst_addr", 32'(io_card_bus_addr), 32'd0);
    check("rst_mosi", 32'(io_card_bus_mosi), 32'd0);
    reset = 1'b0;
    tick(10);
    io_gba_wr_n = 1'b1;
    io_gba_cs2_n = 1'b1;
    tick(S + 4);
    check("arm_no_write", 32'(io_write_count), 32'd0);

    // Directed sequence.
    do_write(16'h0001, 8'h42, 8, S + 2, 1'b0, 1'b0);
    check("first_count", 32'(io_write_count), 32'd1);
    do_write(16'h0002, 8'hAA, S + 1, S + 1, 1'b0, 1'b0);
    do_write(16'h0003, 8'h55, S + 3, S + 2, 1'b0, 1'b0);
    do_read(16'h0001, 8'h42, S + 4);
    do_read(16'h0003, 8'h55, S + 4);
    do_read(16'h0002, 8'hAA, S + 5);

    // Read and write strobes together: the write wins, no output enable.
    do_write(16'h0010, 8'hC3, S + 4, S + 2, 1'b0, 1'b1);
    check("both_count", 32'(io_write_count), 32'd4);
    do_read(16'h0010, 8'hC3, S + 3);

    // Chip select high: strobes are ignored.
    for (int k = 0; k < 3; k++) do_write(16'h0020 + 16'(k), 8'h11, S + 3, S + 1, 1'b1, 1'b0);
    check("cs_high_count", 32'(io_write_count), 32'd4);

    // One-cycle glitch: at most one write, and only with the glitch address/data.
    glitch_win = 1'b1;
    io_gba_addr = glitch_addr;
    io_gba_data_in = glitch_data;
    io_gba_cs2_n = 1'b0;
    io_gba_wr_n = 1'b0;
    tick(1);
    io_gba_wr_n = 1'b1;
    tick(S + 5);
    io_gba_cs2_n = 1'b1;
    glitch_win = 1'b0;
    check("glitch_at_most_one", 32'(glitch_seen > 1), 32'd0);
    model_count += glitch_seen;
    if (glitch_seen == 1) begin
      model_mem[glitch_addr] = glitch_data;
      model_valid[glitch_addr] = 1'b1;
    end
    check("glitch_count", 32'(io_write_count), 32'(model_count[15:0]));

    // Randomised traffic over a small address window so reads hit prior writes.
    for (int n = 0; n < 150; n++) begin
      a = 16'h0100 + 16'($urandom_range(0, 15));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0 || !model_valid[a]) begin
        do_write(a, d, S + 1 + int'($urandom_range(0, 4)), S + 1 + int'($urandom_range(0, 3)),
                 1'b0, $urandom_range(0, 5) == 0);
      end else begin
        do_read(a, model_mem[a], S + 3 + int'($urandom_range(0, 4)));
      end
    end

    tick(5);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("final_count", 32'(io_write_count), 32'(model_count[15:0]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
